// File: rtl/tmds_encoder.sv
// tmds_encoder: per-channel DVI/HDMI TMDS encoder, 2-stage pipeline, bit-reversed 10-bit output.
// Define TMDS_TERC4_EN to add data-island TERC4 encoding through i_island / i_aux.
module tmds_encoder (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_de,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctl,
`ifdef TMDS_TERC4_EN
    input  logic       i_island,
    input  logic [3:0] i_aux,
`endif
    output logic [9:0] o_word
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Serializer shifts word bit 9 first, TMDS wants q_out[0] first.
    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = v[9-i];
        end
        return r;
    endfunction

    function automatic logic [9:0] ctl_token(input logic [1:0] c);
        logic [9:0] t;
        unique case (c)
            2'b00: t = 10'b1101010100;
            2'b01: t = 10'b0010101011;
            2'b10: t = 10'b0101010100;
            2'b11: t = 10'b1010101011;
        endcase
        return t;
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4_code(input logic [3:0] a);
        logic [9:0] t;
        unique case (a)
            4'h0: t = 10'b1010011100;
            4'h1: t = 10'b1001100011;
            4'h2: t = 10'b1011100100;
            4'h3: t = 10'b1011100010;
            4'h4: t = 10'b0101110001;
            4'h5: t = 10'b0100011110;
            4'h6: t = 10'b0110001110;
            4'h7: t = 10'b0100111100;
            4'h8: t = 10'b1011001100;
            4'h9: t = 10'b0100111001;
            4'hA: t = 10'b0110011100;
            4'hB: t = 10'b1011000110;
            4'hC: t = 10'b1010001110;
            4'hD: t = 10'b1001110001;
            4'hE: t = 10'b0101100011;
            4'hF: t = 10'b1011000011;
        endcase
        return t;
    endfunction
`endif

    // Stage 1: transition minimization
    logic [3:0] n1;
    logic       use_xnor;
    logic       acc;
    logic [8:0] qm_d;

    always_comb begin
        n1       = popcount8(i_data);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !i_data[0]);
        qm_d     = 9'd0;
        acc      = i_data[0];
        qm_d[0]  = acc;
        for (int i = 1; i < 8; i++) begin
            acc     = use_xnor ? ~(acc ^ i_data[i]) : (acc ^ i_data[i]);
            qm_d[i] = acc;
        end
        qm_d[8] = ~use_xnor;
    end

    logic [8:0] qm_q;
    logic       de_q;
    logic [1:0] ctl_q;
`ifdef TMDS_TERC4_EN
    logic       island_q;
    logic [3:0] aux_q;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            qm_q  <= 9'd0;
            de_q  <= 1'b0;
            ctl_q <= 2'b00;
        end else begin
            qm_q  <= qm_d;
            de_q  <= i_de;
            ctl_q <= i_ctl;
        end
    end

`ifdef TMDS_TERC4_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            island_q <= 1'b0;
            aux_q    <= 4'h0;
        end else begin
            island_q <= i_island;
            aux_q    <= i_aux;
        end
    end
`endif

    // Stage 2: DC balance against the running disparity
    logic [4:0]        cnt_q;
    logic [4:0]        cnt_d;
    logic [3:0]        n1q;
    logic signed [5:0] diff;
    logic signed [5:0] cnt_ext;
    logic signed [4:0] cnt_nxt;
    logic              cnt_pos;
    logic              cnt_neg;
    logic [9:0]        q_vid;
    logic [9:0]        q_out;
    logic [9:0]        word_d;
    logic [9:0]        word_q;

    always_comb begin
        n1q     = popcount8(qm_q[7:0]);
        diff    = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        cnt_ext = $signed({cnt_q[4], cnt_q});
        cnt_pos = ~cnt_q[4] & (cnt_q != 5'd0);
        cnt_neg = cnt_q[4];
        if ((cnt_q == 5'd0) || (n1q == 4'd4)) begin
            q_vid   = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_nxt = qm_q[8] ? 5'(cnt_ext + diff) : 5'(cnt_ext - diff);
        end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
            q_vid   = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_nxt = 5'(cnt_ext + (qm_q[8] ? 6'sd2 : 6'sd0) - diff);
        end else begin
            q_vid   = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_nxt = 5'(cnt_ext + diff - (qm_q[8] ? 6'sd0 : 6'sd2));
        end
    end

    // Any non-video symbol restarts disparity tracking from zero.
    always_comb begin
        q_out = ctl_token(ctl_q);
        cnt_d = 5'd0;
        if (de_q) begin
            q_out = q_vid;
            cnt_d = cnt_nxt;
        end
`ifdef TMDS_TERC4_EN
        else if (island_q) begin
            q_out = terc4_code(aux_q);
        end
`endif
        word_d = rev10(q_out);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_q <= 10'h0AB;
            cnt_q  <= 5'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_word = word_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: scoreboard bench for tmds_encoder with an output-side TMDS decoder.
// Build with TMDS_TERC4_EN defined to also exercise the data-island path.
module tb_tmds_encoder;

`ifdef TMDS_TERC4_EN
    localparam bit Terc4 = 1'b1;
`else
    localparam bit Terc4 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctl;
    logic       island;
    logic [3:0] aux;
    logic [9:0] word;

    always #5 clk = ~clk;

    tmds_encoder dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_de     (de),
        .i_data   (data),
        .i_ctl    (ctl),
`ifdef TMDS_TERC4_EN
        .i_island (island),
        .i_aux    (aux),
`endif
        .o_word   (word)
    );

    typedef struct {
        logic [9:0] word;
        int         cnt;
        logic       de;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int mcnt = 0;
    int obs_bal = 0;

    logic [9:0] ctl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] terc_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    // Reference encoder; q holds TMDS bits with q[0] sent first.
    task automatic model_word(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                              input logic isl, input logic [3:0] ax, output logic [9:0] w);
        logic [9:0] q;
        logic [8:0] qm;
        int n1, n1q, disp;
        bit xn;
        if (d_e) begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(d[i]);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = !xn;
            n1q = 0;
            for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
            disp = n1q - (8 - n1q);
            if (mcnt == 0 || disp == 0) begin
                q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                mcnt += qm[8] ? disp : -disp;
            end else if ((mcnt > 0 && disp > 0) || (mcnt < 0 && disp < 0)) begin
                q = {1'b1, qm[8], ~qm[7:0]};
                mcnt += 2 * int'(qm[8]) - disp;
            end else begin
                q = {1'b0, qm[8], qm[7:0]};
                mcnt += disp - 2 * (1 - int'(qm[8]));
            end
        end else begin
            q = (isl && Terc4) ? terc_tab[ax] : ctl_tab[c];
            mcnt = 0;
        end
        for (int k = 0; k < 10; k++) w[9-k] = q[k];
    endtask

    // One pixel cycle: check the symbol due now, then drive and score the next input.
    task automatic tick(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                        input logic isl, input logic [3:0] ax,
                        output logic [9:0] ow, output int oc);
        exp_t e;
        logic [9:0] w;
        logic [7:0] x;
        logic [7:0] dec;
        @(negedge clk);
        ow = word;
        oc = int'($signed(dut.cnt_q));
        if (sb.size() == 2) begin
            e = sb.pop_front();
            total++;
            if (word !== e.word) begin
                bad++;
                $display("FAIL sb_word: got %h want %h (de=%0b data=%h)", word, e.word, e.de, e.data);
            end
            total++;
            if (oc != e.cnt) begin
                bad++;
                $display("FAIL sb_cnt: got %0d want %0d", oc, e.cnt);
            end
            if (e.de) begin
                obs_bal += 2 * $countones(word) - 10;
                for (int i = 0; i < 8; i++) x[i] = word[9-i];
                if (word[0]) x = ~x;
                dec[0] = x[0];
                for (int i = 1; i < 8; i++) dec[i] = word[1] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
                total++;
                if (dec !== e.data) begin
                    bad++;
                    $display("FAIL decode: got %h want %h", dec, e.data);
                end
            end else begin
                obs_bal = 0;
            end
            total++;
            if (obs_bal != oc || obs_bal > 10 || obs_bal < -10) begin
                bad++;
                $display("FAIL balance: line balance %0d dut cnt %0d limit +-10", obs_bal, oc);
            end
        end
        de = d_e;
        data = d;
        ctl = c;
        island = isl;
        aux = ax;
        model_word(d_e, d, c, isl, ax, w);
        e.word = w;
        e.cnt = mcnt;
        e.de = d_e;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        total++;
        if (word !== 10'h0AB) begin
            bad++;
            $display("FAIL reset_word: got %h want 0ab", word);
        end
        total++;
        if (dut.cnt_q !== 5'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q);
        end
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_zero_run;
        logic [9:0] ws [8];
        int cs [8];
        for (int i = 0; i < 2; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[0], cs[0]);
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, ws[i], cs[i]);
        for (int i = 3; i < 5; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[i], cs[i]);
        total++;
        if (ws[2] !== 10'h002 || cs[2] != -8) begin
            bad++;
            $display("FAIL zero_run0: got %h/%0d want 002/-8", ws[2], cs[2]);
        end
        total++;
        if (ws[3] !== 10'h3FF || cs[3] != 2) begin
            bad++;
            $display("FAIL zero_run1: got %h/%0d want 3ff/2", ws[3], cs[3]);
        end
        total++;
        if (ws[4] !== 10'h002 || cs[4] != -6) begin
            bad++;
            $display("FAIL zero_run2: got %h/%0d want 002/-6", ws[4], cs[4]);
        end
    endtask

    task automatic test_ctl;
        logic [9:0] ws [8];
        int cs [8];
        logic [9:0] want [4] = '{10'h0AB, 10'h354, 10'h0AA, 10'h355};
        for (int i = 0; i < 2; i++) tick(1'b1, 8'hA5, 2'b00, 1'b0, 4'h0, ws[0], cs[0]);
        for (int i = 0; i < 4; i++) tick(1'b0, 8'hFF, 2'(i), 1'b0, 4'h0, ws[i], cs[i]);
        for (int i = 4; i < 6; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[i], cs[i]);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ws[i+2] !== want[i]) begin
                bad++;
                $display("FAIL ctl_token%0d: got %h want %h", i, ws[i+2], want[i]);
            end
        end
    endtask

    task automatic test_cnt_clear;
        logic [9:0] ws [8];
        int cs [8];
        for (int i = 0; i < 2; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[0], cs[0]);
        tick(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, ws[0], cs[0]);
        tick(1'b0, 8'h00, 2'b01, 1'b0, 4'h0, ws[1], cs[1]);
        tick(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, ws[2], cs[2]);
        tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[3], cs[3]);
        tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[4], cs[4]);
        total++;
        if (ws[2] !== 10'h002 || cs[2] != -8) begin
            bad++;
            $display("FAIL clear_pre: got %h/%0d want 002/-8", ws[2], cs[2]);
        end
        total++;
        if (ws[4] !== 10'h002 || cs[4] != -8) begin
            bad++;
            $display("FAIL clear_post: got %h/%0d want 002/-8", ws[4], cs[4]);
        end
    endtask

    task automatic test_terc4;
        logic [9:0] ws [24];
        int cs [24];
        for (int i = 0; i < 2; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[0], cs[0]);
        tick(1'b0, 8'h00, 2'b00, 1'b1, 4'h0, ws[0], cs[0]);
        for (int i = 1; i <= 16; i++) tick(1'b0, 8'h00, 2'b10, 1'b1, 4'(i - 1), ws[i], cs[i]);
        tick(1'b1, 8'h00, 2'b00, 1'b1, 4'h7, ws[17], cs[17]);
        for (int i = 18; i < 20; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, ws[i], cs[i]);
        total++;
        if (ws[2] !== 10'h0E5) begin
            bad++;
            $display("FAIL terc4_aux0: got %h want 0e5", ws[2]);
        end
        total++;
        if (ws[19] !== 10'h002) begin
            bad++;
            $display("FAIL de_over_island: got %h want 002", ws[19]);
        end
    endtask

    task automatic test_random(input int n);
        logic [9:0] w;
        int c;
        logic d_e;
        logic isl;
        d_e = 1'b1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) d_e = ~d_e;
            isl = Terc4 && ($urandom_range(0, 1) == 1);
            tick(d_e, 8'($urandom), 2'($urandom), isl, 4'($urandom), w, c);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] ws [4];
        int cs [4];
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom), 2'b00, 1'b0, 4'h0, ws[0], cs[0]);
        @(negedge clk);
        rst = 1'b1;
        de = 1'b1;
        data = 8'h00;
        #1;
        total++;
        if (word !== 10'h0AB || dut.cnt_q !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset: got %h/%0d want 0ab/0", word, dut.cnt_q);
        end
        sb.delete();
        mcnt = 0;
        obs_bal = 0;
        @(posedge clk);
        #1;
        total++;
        if (word !== 10'h0AB) begin
            bad++;
            $display("FAIL reset_hold: got %h want 0ab", word);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, ws[i], cs[i]);
        total++;
        if (ws[1] !== 10'h0AB) begin
            bad++;
            $display("FAIL post_reset_idle: got %h want 0ab", ws[1]);
        end
        total++;
        if (ws[2] !== 10'h002 || cs[2] != -8) begin
            bad++;
            $display("FAIL post_reset_first: got %h/%0d want 002/-8", ws[2], cs[2]);
        end
    endtask

    initial begin
        logic [9:0] w;
        int c;
        rst = 1'b1;
        de = 1'b0;
        data = 8'h00;
        ctl = 2'b00;
        island = 1'b0;
        aux = 4'h0;
        #1;
        test_reset();
        test_zero_run();
        test_ctl();
        test_cnt_clear();
        if (Terc4) test_terc4();
        test_random(20000);
        test_reset_mid();
        test_random(2000);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, w, c);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
